param_memory_buffer: RTL and testbench
======================================

# param_memory_buffer

Parametrised synchronous FIFO. It is the successor to the fixed 8-bit memory buffer, with configurable data width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, a read-data valid strobe, and overflow/underflow error pulses. It sits between a producer and a consumer in the same clock domain. It is the standard buffering element for new datapaths.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; must be a power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- clear  input  1  synchronous flush; empties FIFO, data contents don't care
- en_w  input  1  write request
- data_in  input  DATA_W  write data, sampled when a write is accepted
- en_r  input  1  read request
- data_out  output  DATA_W  registered read data
- data_valid  output  1  high for one cycle when data_out holds a newly read word
- full_flag  output  1  count == DEPTH
- empty_flag  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write request rejected
- underflow  output  1  one-cycle pulse: read request rejected

## Operation
- Storage: DEPTH×DATA_W register array. Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write accept rule: wr_ok = en_w & (!full_flag | rd_ok).
- Read accept rule: rd_ok = en_r & !empty_flag. There is no fall-through: a read on an empty FIFO is rejected even if a write occurs in the same cycle.
- Accepted write: mem[wptr] ← data_in, then wptr increments.
- Accepted read: data_out ← mem[rptr], then rptr increments, and data_valid = 1 on the following cycle.
- Count update: count += wr_ok − rd_ok. A simultaneous accepted read and write leaves count unchanged.
- Full FIFO with both en_w and en_r high: both are accepted, count stays DEPTH, and the new word lands in the slot just vacated.
- Empty FIFO with both en_w and en_r high: the write is accepted, the read is rejected, count goes to 1, and underflow pulses.
- overflow = registered (en_w & !wr_ok). underflow = registered (en_r & !rd_ok). Rejected requests never change pointers, count or memory.
- data_out holds its last value whenever no read is accepted.
- All flags (full, empty, almost_full, almost_empty) are decoded combinationally from the registered count. They therefore change in the same cycle as count.
- clear has priority over en_w and en_r. On the next edge, pointers and count go to 0, and data_valid, overflow and underflow go to 0. data_out is retained. Requests in the clear cycle are dropped and raise no error pulse.
- rst = 0 takes effect immediately and asynchronously. Reset values:
  - count = 0, pointers = 0
  - data_out = 0, data_valid = 0
  - empty_flag = 1, full_flag = 0
  - almost_empty = 1, almost_full = 0 (given legal thresholds)
  - overflow = 0, underflow = 0
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored data. Release is synchronous to clk from the design's point of view: the first accepted operation occurs on the first rising edge with rst = 1.

## Timing
- Write-to-read latency: a word written at edge N is readable (empty_flag = 0) after edge N. A read requested at edge N+1 presents data on data_out after edge N+1, with data_valid high in that cycle.
- Read latency: 1 cycle from en_r sampled to data_out/data_valid.
- Throughput: one write and one read per cycle, sustained.
- Flags and count: valid 1 cycle after the causing edge, with no further delay.
- Error pulses: exactly 1 cycle wide per rejected request, aligned with the cycle after the request.

## Test plan
- **Reset.** Apply rst = 0 mid-stream with 3 entries stored, then release. Required: count = 0, empty_flag = 1, almost_empty = 1, data_out = 00, data_valid = 0. A read then raises underflow = 1 for one cycle.
- **Fill and drain** (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1). Write A5, 5A, 3C, C3. Required:
  - almost_empty drops at count = 2
  - almost_full rises at count = 3
  - full_flag rises at count = 4
  - a 5th write (77) gives overflow = 1 and count stays 4
  - draining four reads yields A5, 5A, 3C, C3, each with data_valid = 1, and ends with empty_flag = 1
- **Wrap-around.** Run 10 write/read pairs, one of each per cycle, with data 00..09 on a DEPTH=4 FIFO. Required: data_out sequence 00..09 in order, count ≤ 1 throughout, no error pulses.
- **Simultaneous access when full.** Fill with 11, 22, 33, 44, then write 55 and read in the same cycle. Required: data_out = 11, count = 4, no overflow. Subsequent reads return 22, 33, 44, 55.
- **Simultaneous access when empty.** With the FIFO empty, write 99 and read in the same cycle. Required: underflow = 1, count = 1, data_valid = 0. The next read returns 99.
- **Clear.** With count = 3, assert clear together with en_w and en_r. Required: count = 0, empty_flag = 1, no overflow/underflow, data_out unchanged. A subsequent write of AB then a read returns AB.

Source files
------------

// File: rtl/param_memory_buffer.sv
// param_memory_buffer: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, flush and error pulses.
module param_memory_buffer #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    en_w,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    en_r,
   output logic [DATA_W-1:0]       data_out,
   output logic                    data_valid,
   output logic                    full_flag,
   output logic                    empty_flag,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              wr_ok, rd_ok, wr_en;

   // Flags decode straight from the registered count.
   assign full_flag    = (count_q == CW'(DEPTH));
   assign empty_flag   = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));

   assign count      = count_q;
   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign overflow   = ovf_q;
   assign underflow  = udf_q;

   always_comb begin
      rd_ok   = en_r & ~empty_flag;
      wr_ok   = en_w & (~full_flag | rd_ok);
      wr_en   = 1'b0;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         wr_en = wr_ok;
         if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
         end
         if (rd_ok) begin
            rptr_d  = rptr_q + AW'(1);
            dout_d  = mem_q[rptr_q];
            valid_d = 1'b1;
         end
         count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
         ovf_d   = en_w & ~wr_ok;
         udf_d   = en_r & ~rd_ok;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_param_memory_buffer.sv
// Bench for param_memory_buffer: directed scenarios plus random traffic
// checked against a queue-based FIFO model.
module tb_param_memory_buffer;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int AF = 3;
   localparam int AE = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clear = 1'b0;
   logic          en_w = 1'b0;
   logic          en_r = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          full_flag, empty_flag, almost_full, almost_empty;
   logic [2:0]    count;
   logic          overflow, underflow;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   logic          m_valid = 1'b0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;

   param_memory_buffer #(
      .DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .en_w(en_w), .data_in(data_in), .en_r(en_r),
      .data_out(data_out), .data_valid(data_valid),
      .full_flag(full_flag), .empty_flag(empty_flag),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".full"}, 32'(full_flag), 32'(n == DP));
      chk({tag, ".empty"}, 32'(empty_flag), 32'(n == 0));
      chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
      chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
   endtask

   // One clock of traffic; the model applies FIFO rules to a queue.
   task automatic step(input string tag, input logic c, input logic w,
                       input logic r, input logic [DW-1:0] d);
      logic rd, wr;
      clear = c; en_w = w; en_r = r; data_in = d;
      @(posedge clk);
      #1;
      clear = 1'b0; en_w = 1'b0; en_r = 1'b0;
      if (c) begin
         q.delete();
         m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         rd = r && (q.size() > 0);
         wr = w && (q.size() < DP || rd);
         m_valid = rd;
         if (rd) m_dout = q.pop_front();
         if (wr) q.push_back(d);
         m_ovf = w && !wr;
         m_udf = r && !rd;
      end
      check_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] fill [4];
      fill[0] = 8'hA5; fill[1] = 8'h5A; fill[2] = 8'h3C; fill[3] = 8'hC3;

      #2;
      model_reset();
      check_all("por");
      #10 rst = 1'b1;
      @(posedge clk); #1;

      // Reset mid-stream with three entries stored
      step("rs_w0", 0, 1, 0, 8'h01);
      step("rs_w1", 0, 1, 0, 8'h02);
      step("rs_w2", 0, 1, 1, 8'h03);
      step("rs_w3", 0, 1, 0, 8'h04);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      #3 rst = 1'b1;
      step("rs_rd", 0, 0, 1, 8'h00);
      step("rs_idle", 0, 0, 0, 8'h00);

      // Fill and drain with thresholds
      foreach (fill[i]) step($sformatf("fill%0d", i), 0, 1, 0, fill[i]);
      step("fill_ovf", 0, 1, 0, 8'h77);
      for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 0, 0, 1, 8'h00);
      step("drain_idle", 0, 0, 0, 8'h00);

      // Wrap-around with paired write/read
      step("wrap_pre", 0, 1, 0, 8'h00);
      for (int i = 1; i < 10; i++) step($sformatf("wrap%0d", i), 0, 1, 1, DW'(i));
      step("wrap_last", 0, 0, 1, 8'h00);

      // Simultaneous access when full
      step("sf_w0", 0, 1, 0, 8'h11);
      step("sf_w1", 0, 1, 0, 8'h22);
      step("sf_w2", 0, 1, 0, 8'h33);
      step("sf_w3", 0, 1, 0, 8'h44);
      step("sf_both", 0, 1, 1, 8'h55);
      for (int i = 0; i < 4; i++) step($sformatf("sf_rd%0d", i), 0, 0, 1, 8'h00);

      // Simultaneous access when empty
      step("se_both", 0, 1, 1, 8'h99);
      step("se_rd", 0, 0, 1, 8'h00);

      // Clear wins over requests
      step("cl_w0", 0, 1, 0, 8'hD1);
      step("cl_w1", 0, 1, 0, 8'hD2);
      step("cl_w2", 0, 1, 0, 8'hD3);
      step("cl_w3", 0, 1, 1, 8'hD4);
      step("cl_clr", 1, 1, 1, 8'hEE);
      step("cl_wab", 0, 1, 0, 8'hAB);
      step("cl_rab", 0, 0, 1, 8'h00);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($sformatf("rnd%0d", i), ($urandom_range(0, 39) == 0),
              1'($urandom), 1'($urandom), DW'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
